// File: rtl/fdiv_sched_pkg.sv
`default_nettype none
// ============================================================================
// fdiv_sched_pkg : shared types and round-robin pick helper for fdiv_sched
// Rev 1.0
// ============================================================================
package fdiv_sched_pkg;

   localparam int unsigned ID_W    = 3;
   localparam int unsigned MAX_REQ = 8;

   typedef logic [31:0] float_t;

   typedef struct packed {
      logic            v;
      logic [ID_W-1:0] id;
      logic            dz;
   } tag_t;

   // First requester with valid set, searching upward from ptr and wrapping at nreq.
   // Result is meaningless when no valid bit is set; callers gate it with |valid.
   function automatic logic [ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    ptr,
                                                input int                 nreq);
      logic [ID_W-1:0] pick;
      logic            found;
      int              idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < int'(MAX_REQ); k++) begin
         idx = (int'(ptr) + k) % nreq;
         if (!found && (k < nreq) && valid[3'(idx)]) begin
            pick  = 3'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage : fdiv_sched_pkg
`default_nettype wire

// File: rtl/fdiv_tag_pipe.sv
`default_nettype none
// ============================================================================
// fdiv_tag_pipe : fixed-depth tag shift register tracking in-flight fdiv ops
// Rev 1.0
// ============================================================================
module fdiv_tag_pipe
   import fdiv_sched_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rstn,
   input  tag_t tag_i,
   output tag_t tail_o,
   output logic pre_tail_v_o
);

   tag_t stage_q [DEPTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < DEPTH; s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         stage_q[0] <= tag_i;
         for (int s = 1; s < DEPTH; s++) begin
            stage_q[s] <= stage_q[s-1];
         end
      end
   end

   assign tail_o       = stage_q[DEPTH-1];
   // One stage ahead of the tail: fdiv_y for this op is valid now.
   assign pre_tail_v_o = stage_q[DEPTH-2].v;

endmodule : fdiv_tag_pipe
`default_nettype wire

// File: rtl/fdiv_sched.sv
`default_nettype none
// ============================================================================
// fdiv_sched : round-robin sharing of one fixed-latency pipelined fdiv unit
// Option macro FDIV_SCHED_DIVZERO_EN enables the divide-by-zero flag path.
// Rev 1.0
// ============================================================================
module fdiv_sched
   import fdiv_sched_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int NSTAGE = 7
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_x1,
   input  logic [NREQ*32-1:0]   req_x2,
   output logic [NREQ-1:0]      resp_valid,
   output logic [31:0]          resp_y,
   output logic                 resp_dz,
   output logic [31:0]          fdiv_x1,
   output logic [31:0]          fdiv_x2,
   input  logic [31:0]          fdiv_y,
   output logic                 busy
);

   localparam int CNT_W = $clog2(NSTAGE + 2);

`ifdef FDIV_SCHED_DIVZERO_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  grant_id;
   logic             issue;
   float_t           x1_sel, x2_sel;
   float_t           fdiv_x1_q, fdiv_x1_d;
   float_t           fdiv_x2_q, fdiv_x2_d;
   float_t           resp_y_q, resp_y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   tag_t             tag_d;
   tag_t             tail;
   logic             pre_tail_v;

   always_comb begin
      grant_id  = rr_pick(8'(req_valid), ptr_q, NREQ);
      issue     = |req_valid;
      req_ready = '0;
      x1_sel    = '0;
      x2_sel    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (issue && (grant_id == 3'(i))) begin
            req_ready[i] = 1'b1;
            x1_sel       = req_x1[32*i +: 32];
            x2_sel       = req_x2[32*i +: 32];
         end
      end
      ptr_d = ptr_q;
      if (issue) begin
         ptr_d = (grant_id == 3'(NREQ - 1)) ? '0 : grant_id + 3'd1;
      end
   end

   always_comb begin
      tag_d    = '0;
      tag_d.v  = issue;
      tag_d.id = issue ? grant_id : '0;
      tag_d.dz = DZ_EN && issue && (x2_sel[30:23] == 8'd0) && (x1_sel[30:23] != 8'd0);
   end

   always_comb begin
      fdiv_x1_d = fdiv_x1_q;
      fdiv_x2_d = fdiv_x2_q;
      if (issue) begin
         fdiv_x1_d = x1_sel;
         fdiv_x2_d = x2_sel;
      end
      // Capture the quotient on the edge its tag reaches the tail.
      resp_y_d = pre_tail_v ? fdiv_y : resp_y_q;
      unique case ({issue, tail.v})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q     <= '0;
         fdiv_x1_q <= '0;
         fdiv_x2_q <= '0;
         resp_y_q  <= '0;
         cnt_q     <= '0;
      end else begin
         ptr_q     <= ptr_d;
         fdiv_x1_q <= fdiv_x1_d;
         fdiv_x2_q <= fdiv_x2_d;
         resp_y_q  <= resp_y_d;
         cnt_q     <= cnt_d;
      end
   end

   fdiv_tag_pipe #(
      .DEPTH (NSTAGE + 1)
   ) u_tag_pipe (
      .clk          (clk),
      .rstn         (rstn),
      .tag_i        (tag_d),
      .tail_o       (tail),
      .pre_tail_v_o (pre_tail_v)
   );

   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         resp_valid[i] = tail.v && (tail.id == 3'(i));
      end
   end

   assign resp_dz = DZ_EN && tail.v && tail.dz;
   assign resp_y  = resp_y_q;
   assign fdiv_x1 = fdiv_x1_q;
   assign fdiv_x2 = fdiv_x2_q;
   assign busy    = (cnt_q != '0);

endmodule : fdiv_sched
`default_nettype wire

// File: tb/tb_fdiv_sched.sv
`default_nettype none
// ============================================================================
// tb_fdiv_sched : directed + random bench for fdiv_sched with a behavioural fdiv
// Rev 1.0
// ============================================================================
module tb_fdiv_sched;

   localparam int NREQ   = 2;
   localparam int NSTAGE = 7;

`ifdef FDIV_SCHED_DIVZERO_EN
   localparam bit DZ_ON = 1'b1;
`else
   localparam bit DZ_ON = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*32-1:0]  req_x1 = '0;
   logic [NREQ*32-1:0]  req_x2 = '0;
   logic [NREQ-1:0]     resp_valid;
   logic [31:0]         resp_y;
   logic                resp_dz;
   logic [31:0]         fdiv_x1;
   logic [31:0]         fdiv_x2;
   logic [31:0]         fdiv_y;
   logic                busy;

   always #5 clk = ~clk;

   fdiv_sched #(.NREQ(NREQ), .NSTAGE(NSTAGE)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x1     (req_x1),
      .req_x2     (req_x2),
      .resp_valid (resp_valid),
      .resp_y     (resp_y),
      .resp_dz    (resp_dz),
      .fdiv_x1    (fdiv_x1),
      .fdiv_x2    (fdiv_x2),
      .fdiv_y     (fdiv_y),
      .busy       (busy)
   );

   // Single precision via double arithmetic; truncating, flush-to-zero.
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) return 0.0;
      d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      int          e;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
      if (e >= 255)            return {d[63], 8'hFF, 23'h0};
      if (e <= 0)              return {d[63], 31'h0};
      return {d[63], 8'(e), d[51:29]};
   endfunction

   function automatic logic [31:0] f32div(input logic [31:0] a, input logic [31:0] b);
      return r2f(f2r(a) / f2r(b));
   endfunction

   // The operand register edge counts as the first of the NSTAGE edges,
   // so the unit itself holds NSTAGE-1 register stages.
   logic [31:0] fd_pipe [NSTAGE-1];
   always @(posedge clk) begin
      fd_pipe[0] <= f32div(fdiv_x1, fdiv_x2);
      for (int k = 1; k < NSTAGE - 1; k++) fd_pipe[k] <= fd_pipe[k-1];
   end
   assign fdiv_y = fd_pipe[NSTAGE-2];

   typedef struct {
      int          due;
      int          owner;
      logic [31:0] y;
      logic        dz;
   } exp_t;

   exp_t            sbq[$];
   int              n_assert = 0;
   int              n_fail   = 0;
   int              cyc      = 0;
   int              mptr     = 0;
   int              n_issue  = 0;
   int              n_seen   = 0;
   logic [31:0]     last_y   = '0;
   logic [31:0]     exp_fx1  = '0;
   logic [31:0]     exp_fx2  = '0;
   logic [NREQ-1:0] obs_rdy, obs_rv;
   logic [31:0]     obs_y;
   logic            obs_dz, obs_busy;
   logic [NREQ-1:0] grants [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive requests, compare against the model, advance.
   task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*32-1:0] a,
                       input logic [NREQ*32-1:0] b);
      int              g;
      int              idx;
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] exp_rv;
      exp_t            e;
      check("fdiv_x1", fdiv_x1, exp_fx1);
      check("fdiv_x2", fdiv_x2, exp_fx2);
      req_valid = v;
      req_x1    = a;
      req_x2    = b;
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         idx = (mptr + k) % NREQ;
         if (g < 0 && v[idx]) g = idx;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      exp_rv = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) exp_rv[sbq[0].owner] = 1'b1;
      check("resp_valid", 32'(resp_valid), 32'(exp_rv));
      check("busy", {31'b0, busy}, {31'b0, sbq.size() > 0});
      if (exp_rv != '0) begin
         last_y = sbq[0].y;
         check("resp_dz", {31'b0, resp_dz}, {31'b0, sbq[0].dz});
         void'(sbq.pop_front());
      end else begin
         check("resp_dz_idle", {31'b0, resp_dz}, 32'd0);
      end
      check("resp_y", resp_y, last_y);
      if (resp_valid != '0) n_seen++;
      obs_rdy  = req_ready;
      obs_rv   = resp_valid;
      obs_y    = resp_y;
      obs_dz   = resp_dz;
      obs_busy = busy;
      if (g >= 0) begin
         e.due   = cyc + NSTAGE + 1;
         e.owner = g;
         e.y     = f32div(a[32*g +: 32], b[32*g +: 32]);
         e.dz    = DZ_ON && (b[32*g+23 +: 8] == 8'd0) && (a[32*g+23 +: 8] != 8'd0);
         sbq.push_back(e);
         exp_fx1 = a[32*g +: 32];
         exp_fx2 = b[32*g +: 32];
         mptr    = (g + 1) % NREQ;
         n_issue++;
      end
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, '0, '0);
   endtask

   task automatic apply_reset();
      req_valid = '0;
      rstn      = 1'b0;
      #1;
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_y", resp_y, 32'd0);
      check("rst_resp_dz", {31'b0, resp_dz}, 32'd0);
      check("rst_fdiv_x1", fdiv_x1, 32'd0);
      check("rst_fdiv_x2", fdiv_x2, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rstn = 1'b1;
      sbq.delete();
      mptr    = 0;
      last_y  = '0;
      exp_fx1 = '0;
      exp_fx2 = '0;
      @(posedge clk);
      #2;
      cyc = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] rv;

      // Single op: 3.0 / 2.0 from requester 0
      #2;
      apply_reset();
      step(2'b01, {32'h0, 32'h40400000}, {32'h0, 32'h40000000});
      idle(8);
      check("single_rv_c8", 32'(obs_rv), 32'h1);
      check("single_y_c8", obs_y, 32'h3FC00000);
      check("single_busy_c8", {31'b0, obs_busy}, 32'd1);
      idle(1);
      check("single_busy_c9", {31'b0, obs_busy}, 32'd0);

      // Both requesters valid for four cycles
      apply_reset();
      for (int c = 0; c < 4; c++) begin
         step(2'b11, {32'h41200000 + 32'(c), 32'h40A00000}, {32'h40800000, 32'h3F800000 + 32'(c)});
         grants[c] = obs_rdy;
      end
      check("alt_g0", 32'(grants[0]), 32'h1);
      check("alt_g1", 32'(grants[1]), 32'h2);
      check("alt_g2", 32'(grants[2]), 32'h1);
      check("alt_g3", 32'(grants[3]), 32'h2);
      idle(10);

      // Requester 0 hogging, requester 1 joins at cycle 5
      apply_reset();
      for (int c = 0; c < 20; c++) begin
         step({c >= 5, 1'b1}, {32'h40000000, 32'h3F800000}, {32'h40400000, 32'h40000000});
         if (c == 5) check("join_grant_c5", 32'(obs_rdy), 32'h2);
      end
      idle(10);

      // Reset with four ops in flight
      apply_reset();
      for (int c = 0; c < 4; c++) step(2'b11, {32'h40E00000, 32'h40400000}, {32'h40000000, 32'h3F000000});
      apply_reset();
      idle(12);

      // Divide by zero
      apply_reset();
      step(2'b01, {32'h0, 32'h3F800000}, {32'h0, 32'h00000000});
      idle(8);
      check("dz_rv_c8", 32'(obs_rv), 32'h1);
      check("dz_flag_c8", {31'b0, obs_dz}, {31'b0, DZ_ON});
      idle(2);

      // Random traffic
      apply_reset();
      n_issue = 0;
      n_seen  = 0;
      for (int c = 0; c < 1000; c++) begin
         rv = NREQ'($urandom_range(0, 3));
         step(rv, {$urandom, $urandom}, {$urandom, $urandom});
      end
      idle(NSTAGE + 3);
      check("rand_resp_count", 32'(n_seen), 32'(n_issue));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_fdiv_sched
`default_nettype wire
